sdram_dump_core: RTL and testbench

Streams a region of SDRAM out over the RS232 UART, in the same framing the loader consumes. It is the transmit-side counterpart of the RS232-to-SDRAM load path. On a start pulse it sends the following, all as bytes MSB first:
- a 4-byte start address;
- a 4-byte word count;
- N 32-bit data words read from SDRAM.

Host tools can capture SDRAM contents and replay the capture into the loader unchanged. It sits between the UART Avalon-MM slave and a dedicated SDRAM read port of the SDRAM arbiter.

---
 rtl/sdram_dump_core_if.sv | 37 +++
 rtl/sdram_dump_core.sv | 190 +++++++++++++++++++
 tb/tb_sdram_dump_core.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_dump_core_if.sv
// sdram_dump_core_if
// Bundles the two buses the dump core drives: the Avalon-MM master port
// toward the UART register slave, and the dedicated read port toward the
// SDRAM arbiter.
//   master modport : the dump core (drives requests, receives responses)
//   slave  modport : the UART slave / SDRAM arbiter side
// Signals:
//   avm_address[4:0], avm_read, avm_write, avm_writedata[31:0]  core -> UART
//   avm_readdata[31:0], avm_waitrequest                         UART -> core
//   dumpdata_addr[22:0], dumpdata_read                           core -> SDRAM
//   dumpdata_readdata[31:0], dumpdata_sdram_finished             SDRAM -> core
interface sdram_dump_core_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [22:0] dumpdata_addr;
    logic        dumpdata_read;
    logic [31:0] dumpdata_readdata;
    logic        dumpdata_sdram_finished;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        output dumpdata_addr, dumpdata_read,
        input  avm_readdata, avm_waitrequest,
        input  dumpdata_readdata, dumpdata_sdram_finished
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        input  dumpdata_addr, dumpdata_read,
        output avm_readdata, avm_waitrequest,
        output dumpdata_readdata, dumpdata_sdram_finished
    );
endinterface

// File: rtl/sdram_dump_core.sv
// sdram_dump_core
// Streams a region of SDRAM out through the UART in the loader's framing:
// 4-byte start address, 4-byte word count, then N 32-bit words, every field
// sent MSB first. Each byte is sent by polling the UART status register
// until the TX holding register is free, then writing the TX data register.
// Ports:
//   avm_clk, avm_rst    clock; asynchronous active-high reset
//   start               one-cycle request, honoured only when idle
//   start_addr[22:0]    first SDRAM word address, latched on start
//   word_count[31:0]    number of data words, latched on start
//   busy                high while a frame is in progress
//   done                one-cycle pulse after the last byte is accepted
//   bus                 UART Avalon master + SDRAM read port (master modport)
// All outputs are registered: the combinational process computes the value
// every output register takes at the next edge.
module sdram_dump_core #(
    parameter int RX_BASE     = 0,
    parameter int TX_BASE     = 4,
    parameter int STATUS_BASE = 8,
    parameter int TX_OK_BIT   = 6
) (
    input  logic              avm_clk,
    input  logic              avm_rst,
    input  logic              start,
    input  logic [22:0]       start_addr,
    input  logic [31:0]       word_count,
    output logic              busy,
    output logic              done,
    sdram_dump_core_if.master bus
);
    localparam logic [4:0] TX_ADDR     = 5'(TX_BASE);
    localparam logic [4:0] STATUS_ADDR = 5'(STATUS_BASE);

    // The RX register is never touched, but it must not alias the two
    // registers this core does use.
    generate
        if (RX_BASE == TX_BASE || RX_BASE == STATUS_BASE || TX_BASE == STATUS_BASE) begin : g_addr_clash
            $error("sdram_dump_core: UART register addresses must be distinct");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_QUERY_TX, S_WRITE, S_FETCH, S_FINISH} state_t;
    typedef enum logic [1:0] {PH_ADDR, PH_COUNT, PH_DATA} phase_t;

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [31:0] shift_r, shift_n;
    logic [22:0] addr_r, addr_n;
    logic [31:0] remaining, remaining_n;
    logic        busy_n, done_n;
    logic [4:0]  avm_address_n;
    logic        avm_read_n, avm_write_n;
    logic [31:0] avm_writedata_n;
    logic [22:0] dd_addr_n;
    logic        dd_read_n;

    logic poll_ok, wr_ack;
    assign poll_ok = bus.avm_read && !bus.avm_waitrequest && bus.avm_readdata[TX_OK_BIT];
    assign wr_ack  = bus.avm_write && !bus.avm_waitrequest;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state             <= S_IDLE;
            phase             <= PH_ADDR;
            byte_cnt          <= '0;
            shift_r           <= '0;
            addr_r            <= '0;
            remaining         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            bus.avm_address   <= STATUS_ADDR;
            bus.avm_read      <= 1'b0;
            bus.avm_write     <= 1'b0;
            bus.avm_writedata <= '0;
            bus.dumpdata_addr <= '0;
            bus.dumpdata_read <= 1'b0;
        end else begin
            state             <= state_n;
            phase             <= phase_n;
            byte_cnt          <= byte_cnt_n;
            shift_r           <= shift_n;
            addr_r            <= addr_n;
            remaining         <= remaining_n;
            busy              <= busy_n;
            done              <= done_n;
            bus.avm_address   <= avm_address_n;
            bus.avm_read      <= avm_read_n;
            bus.avm_write     <= avm_write_n;
            bus.avm_writedata <= avm_writedata_n;
            bus.dumpdata_addr <= dd_addr_n;
            bus.dumpdata_read <= dd_read_n;
        end
    end

    always_comb begin
        state_n         = state;
        phase_n         = phase;
        byte_cnt_n      = byte_cnt;
        shift_n         = shift_r;
        addr_n          = addr_r;
        remaining_n     = remaining;
        busy_n          = busy;
        done_n          = 1'b0;
        avm_address_n   = bus.avm_address;
        avm_read_n      = bus.avm_read;
        avm_write_n     = bus.avm_write;
        avm_writedata_n = bus.avm_writedata;
        dd_addr_n       = bus.dumpdata_addr;
        dd_read_n       = bus.dumpdata_read;

        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_n        = start_addr;
                    remaining_n   = word_count;
                    shift_n       = {9'b0, start_addr};
                    phase_n       = PH_ADDR;
                    byte_cnt_n    = '0;
                    busy_n        = 1'b1;
                    avm_read_n    = 1'b1;
                    avm_address_n = STATUS_ADDR;
                    state_n       = S_QUERY_TX;
                end
            end

            S_QUERY_TX: begin
                // A completed poll without TX_OK simply repeats.
                if (poll_ok) begin
                    avm_read_n      = 1'b0;
                    avm_write_n     = 1'b1;
                    avm_address_n   = TX_ADDR;
                    avm_writedata_n = {24'b0, shift_r[31:24]};
                    state_n         = S_WRITE;
                end
            end

            S_WRITE: begin
                if (wr_ack) begin
                    avm_write_n   = 1'b0;
                    avm_address_n = STATUS_ADDR;
                    shift_n       = shift_r << 8;
                    byte_cnt_n    = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        byte_cnt_n = '0;
                        if (phase == PH_ADDR) begin
                            // The count field is held in remaining until now.
                            shift_n    = remaining;
                            phase_n    = PH_COUNT;
                            avm_read_n = 1'b1;
                            state_n    = S_QUERY_TX;
                        end else if (remaining != 32'd0) begin
                            dd_read_n = 1'b1;
                            dd_addr_n = addr_r;
                            state_n   = S_FETCH;
                        end else begin
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            state_n = S_FINISH;
                        end
                    end else begin
                        avm_read_n = 1'b1;
                        state_n    = S_QUERY_TX;
                    end
                end
            end

            S_FETCH: begin
                if (bus.dumpdata_sdram_finished) begin
                    shift_n       = bus.dumpdata_readdata;
                    addr_n        = addr_r + 23'd1;
                    remaining_n   = remaining - 32'd1;
                    phase_n       = PH_DATA;
                    dd_read_n     = 1'b0;
                    avm_read_n    = 1'b1;
                    avm_address_n = STATUS_ADDR;
                    state_n       = S_QUERY_TX;
                end
            end

            S_FINISH: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_sdram_dump_core.sv
// tb_sdram_dump_core
// Randomized bench for sdram_dump_core. A UART slave and SDRAM port model
// respond at the falling edge; the expected frame is built directly from the
// framing rules (address, count, then N memory words, all MSB first) and
// compared byte by byte with what the UART model accepted.
module tb_sdram_dump_core;
    localparam int TX_OK_BIT = 6;

    logic        avm_clk = 1'b0;
    logic        avm_rst;
    logic        start;
    logic [22:0] start_addr;
    logic [31:0] word_count;
    logic        busy;
    logic        done;

    sdram_dump_core_if bus();

    sdram_dump_core #(
        .RX_BASE(0), .TX_BASE(4), .STATUS_BASE(8), .TX_OK_BIT(TX_OK_BIT)
    ) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst), .start(start),
        .start_addr(start_addr), .word_count(word_count),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 avm_clk = ~avm_clk;

    int n_total, n_bad;
    int cyc = 0;
    always @(posedge avm_clk) cyc <= cyc + 1;

    logic [7:0]  got_q[$], exp_q[$];
    logic [22:0] addr_q[$], exp_addr_q[$];
    logic [31:0] mem [logic [22:0]];

    bit          stall_en, bp_en;
    int          lat;
    int          polls, fetch_cnt, ovl_cnt, proto_err, done_cnt, done_cyc, s_cyc;
    bit          done_busy, prev_wr_stall, wait_now;
    logic [31:0] prev_wd, rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [22:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hA5, 1'b0, a[22:16], ~a[7:0]};
    endfunction

    function automatic void push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    endfunction

    function automatic void build_exp(input logic [22:0] a, input logic [31:0] n);
        logic [22:0] wa;
        exp_q.delete();
        exp_addr_q.delete();
        push_word({9'b0, a});
        push_word(n);
        wa = a;
        for (int i = 0; i < int'(n); i++) begin
            exp_addr_q.push_back(wa);
            push_word(mem_rd(wa));
            wa = wa + 23'd1;
        end
    endfunction

    // UART slave + SDRAM port model: decides this cycle's responses and logs
    // the transactions that complete at the coming rising edge.
    initial forever begin
        @(negedge avm_clk);
        if (avm_rst !== 1'b0) begin
            bus.avm_waitrequest         = 1'b0;
            bus.avm_readdata            = '0;
            bus.dumpdata_sdram_finished = 1'b0;
            bus.dumpdata_readdata       = '0;
            polls = 0; fetch_cnt = 0; prev_wr_stall = 0; prev_wd = '0;
        end else begin
            if (bus.avm_read && bus.avm_write) ovl_cnt++;
            if (bus.dumpdata_read && (bus.avm_read || bus.avm_write)) ovl_cnt++;
            wait_now = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
            bus.avm_waitrequest = wait_now;
            rd = $urandom;
            rd[TX_OK_BIT] = bp_en ? (polls >= 5) : 1'b1;
            bus.avm_readdata = rd;
            if (bus.avm_read && !wait_now) begin
                if (bus.avm_address != 5'd8) proto_err++;
                polls++;
            end
            if (prev_wr_stall && (!bus.avm_write || bus.avm_writedata != prev_wd)) proto_err++;
            prev_wr_stall = bus.avm_write && wait_now;
            prev_wd = bus.avm_writedata;
            if (bus.avm_write && !wait_now) begin
                got_q.push_back(bus.avm_writedata[7:0]);
                if (bus.avm_writedata[31:8] != 24'd0 || bus.avm_address != 5'd4) proto_err++;
                polls = 0;
            end
            if (bus.dumpdata_read) begin
                if (fetch_cnt + 1 == lat) begin
                    bus.dumpdata_sdram_finished = 1'b1;
                    bus.dumpdata_readdata = mem_rd(bus.dumpdata_addr);
                    addr_q.push_back(bus.dumpdata_addr);
                    fetch_cnt = 0;
                end else begin
                    bus.dumpdata_sdram_finished = 1'b0;
                    bus.dumpdata_readdata = $urandom;
                    fetch_cnt++;
                end
            end else begin
                bus.dumpdata_sdram_finished = 1'b0;
                bus.dumpdata_readdata = $urandom;
                fetch_cnt = 0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_busy = busy;
            end
        end
    end

    task automatic run_frame(input string tag, input logic [22:0] a, input logic [31:0] n,
                             input bit stall, input bit bp, input int l, input bit ign,
                             input bit chk_time);
        bit fin, pulsed;
        int m;
        stall_en = stall; bp_en = bp; lat = l;
        got_q.delete(); addr_q.delete();
        done_cnt = 0; ovl_cnt = 0; proto_err = 0;
        build_exp(a, n);
        @(negedge avm_clk);
        start = 1'b1; start_addr = a; word_count = n; s_cyc = cyc;
        @(negedge avm_clk);
        start = 1'b0;
        chk({tag, "_busy_c1"}, busy, 1);
        chk({tag, "_poll_c1"}, bus.avm_read, 1);
        fin = 0; pulsed = 0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            @(negedge avm_clk);
            if (ign && !pulsed && got_q.size() >= 9) begin
                start = 1'b1; start_addr = 23'($urandom); word_count = $urandom; pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (done_cnt > 0) fin = 1;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, fin, 1);
        repeat (3) @(negedge avm_clk);
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_nfetch"}, addr_q.size(), exp_addr_q.size());
        m = (addr_q.size() < exp_addr_q.size()) ? addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < m; i++) chk($sformatf("%s_faddr%0d", tag, i), addr_q[i], exp_addr_q[i]);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_at_done"}, done_busy, 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_overlap"}, ovl_cnt, 0);
        chk({tag, "_protocol"}, proto_err, 0);
        if (chk_time && fin) chk({tag, "_latency"}, done_cyc - s_cyc, 17 + int'(n) * (8 + l));
    endtask

    task automatic reset_mid();
        stall_en = 0; bp_en = 0; lat = 2;
        got_q.delete(); addr_q.delete(); done_cnt = 0;
        @(negedge avm_clk);
        start = 1'b1; start_addr = 23'h000456; word_count = 32'h00AB0002;
        @(negedge avm_clk);
        start = 1'b0;
        for (int i = 0; i < 200 && got_q.size() < 6; i++) begin
            @(posedge avm_clk);
            #1;
        end
        chk("rst_reached_byte6", got_q.size(), 6);
        avm_rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", bus.avm_read, 0);
        chk("rst_write", bus.avm_write, 0);
        chk("rst_wdata", bus.avm_writedata, 0);
        chk("rst_addr", bus.avm_address, 8);
        chk("rst_dd_read", bus.dumpdata_read, 0);
        chk("rst_dd_addr", bus.dumpdata_addr, 0);
        repeat (2) @(negedge avm_clk);
        avm_rst = 1'b0;
        repeat (4) @(negedge avm_clk);
        chk("rst_idle_read", bus.avm_read, 0);
        chk("rst_idle_busy", busy, 0);
        chk("rst_no_done", done_cnt, 0);
    endtask

    initial begin
        logic [22:0] ra;
        logic [31:0] rn;
        bit rs, rb;
        int rl;
        n_total = 0; n_bad = 0;
        start = 1'b0; start_addr = '0; word_count = '0;
        avm_rst = 1'b1;
        stall_en = 0; bp_en = 0; lat = 1;
        ovl_cnt = 0; proto_err = 0; done_cnt = 0; done_cyc = 0; s_cyc = 0; done_busy = 0;
        mem[23'h000010] = 32'hDEADBEEF;
        mem[23'h000011] = 32'h01020304;
        mem[23'h7FFFFF] = 32'hCAFEF00D;
        mem[23'h000000] = 32'h89ABCDEF;

        repeat (3) @(negedge avm_clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_read", bus.avm_read, 0);
        chk("reset_write", bus.avm_write, 0);
        chk("reset_wdata", bus.avm_writedata, 0);
        chk("reset_addr", bus.avm_address, 8);
        chk("reset_dd_read", bus.dumpdata_read, 0);
        chk("reset_dd_addr", bus.dumpdata_addr, 0);
        avm_rst = 1'b0;
        @(negedge avm_clk);

        run_frame("hdr",  23'h000123, 32'd0, 0, 0, 3, 0, 1);
        run_frame("two",  23'h000010, 32'd2, 0, 0, 3, 0, 1);
        run_frame("bp",   23'h000010, 32'd2, 1, 1, 4, 0, 0);
        run_frame("wrap", 23'h7FFFFF, 32'd2, 0, 0, 2, 0, 1);
        run_frame("ign",  23'h000010, 32'd2, 0, 0, 1, 1, 1);
        reset_mid();
        run_frame("rerun", 23'h000456, 32'd1, 0, 0, 2, 0, 1);

        for (int k = 0; k < 6; k++) begin
            ra = (k % 3 == 0) ? 23'h7FFFFE : 23'($urandom);
            rn = $urandom_range(0, 3);
            rs = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rl = $urandom_range(1, 5);
            run_frame($sformatf("rnd%0d", k), ra, rn, rs, rb, rl, 0, !rs && !rb);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
